// File: rtl/piso_serializer_tx.sv
// MSB-first parallel-in/serial-out transmitter with a valid/ready load handshake,
// a programmable bit period and an optional idle gap between frames.
module piso_serializer_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             shift_out,
  output logic             shift_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PER_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic             HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [PER_W-1:0]   perCnt_q, perCnt_d;
  logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;

  logic perLast;
  logic bitLast;
  logic gapLast;

  assign perLast = (perCnt_q == PER_LAST);
  assign bitLast = (bitCnt_q == BIT_LAST);
  assign gapLast = (gapCnt_q == GAP_LAST);

  // Outputs decode registered state only; load_ready alone also sees rst.
  assign shift_valid = (state_q == SHIFT);
  assign shift_out   = shift_valid & sreg_q[WIDTH-1];
  assign frame_done  = shift_valid & bitLast & perLast;
  assign busy        = (state_q != IDLE);
  assign load_ready  = (state_q == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      bitCnt_q <= '0;
      perCnt_q <= '0;
      gapCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bitCnt_q <= bitCnt_d;
      perCnt_q <= perCnt_d;
      gapCnt_q <= gapCnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bitCnt_d = bitCnt_q;
    perCnt_d = perCnt_q;
    gapCnt_d = gapCnt_q;

    unique case (state_q)
      IDLE: begin
        if (load_valid && load_ready) begin
          state_d  = SHIFT;
          sreg_d   = data_in;
          bitCnt_d = '0;
          perCnt_d = '0;
        end
      end

      SHIFT: begin
        if (perLast) begin
          perCnt_d = '0;
          sreg_d   = {sreg_q[WIDTH-2:0], 1'b0};
          // The bit counter restarts on the last bit so it never wraps mid-frame.
          if (bitLast) begin
            bitCnt_d = '0;
            gapCnt_d = '0;
            state_d  = HAS_GAP ? GAP : IDLE;
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end else begin
          perCnt_d = perCnt_q + PER_W'(1);
        end
      end

      GAP: begin
        if (gapLast) begin
          gapCnt_d = '0;
          state_d  = IDLE;
        end else begin
          gapCnt_d = gapCnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer_tx.sv
// Bench for piso_serializer_tx: two instances (default pacing and BIT_CYCLES=3/GAP_CYCLES=2)
// share one stimulus stream and are checked every cycle against a frame-timing model.
module tb_piso_serializer_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       loadValid;
  logic [7:0] dataIn;

  logic ready0, so0, sv0, fd0, busy0;
  logic ready1, so1, sv1, fd1, busy1;
  logic [7:0] rx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit         mActive [2];
  int         mT      [2];
  logic [7:0] mWord   [2];

  logic cOut [2];
  logic cValid [2];
  logic cDone [2];
  logic cBusy [2];
  logic cReady [2];

  typedef struct {
    logic [7:0] dataIn;
    logic [7:0] expRx;
    int         expHigh1;
  } vec_t;

  vec_t vecs [6];

  piso_serializer_tx #(.WIDTH(8), .BIT_CYCLES(1), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(dataIn), .load_valid(loadValid),
    .load_ready(ready0), .shift_out(so0), .shift_valid(sv0),
    .frame_done(fd0), .busy(busy0)
  );

  piso_serializer_tx #(.WIDTH(8), .BIT_CYCLES(3), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .data_in(dataIn), .load_valid(loadValid),
    .load_ready(ready1), .shift_out(so1), .shift_valid(sv1),
    .frame_done(fd1), .busy(busy1)
  );

  // Receive end of the loopback: 8-bit shift-left register fed by dut0.
  always @(posedge clk) rx <= {rx[6:0], so0};

  function automatic int bitCycles(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int gapCycles(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // Expected outputs in the current cycle, from the offset to the last accepting edge.
  task automatic modelExpect(input int i, output logic eo, output logic ev,
                             output logic ed, output logic eb, output logic er);
    int off;
    int wb;
    off = cyc - mT[i];
    wb  = W * bitCycles(i);
    ev  = mActive[i] && (off >= 1) && (off <= wb);
    eo  = 1'b0;
    if (ev) eo = mWord[i][W - 1 - (off - 1) / bitCycles(i)];
    ed  = ev && (off == wb);
    eb  = mActive[i] && (off >= 1) && (off <= wb + gapCycles(i));
    er  = !eb && !rst;
  endtask

  task automatic modelEdge();
    logic eo, ev, ed, eb, er;
    for (int i = 0; i < 2; i++) begin
      modelExpect(i, eo, ev, ed, eb, er);
      if (rst) begin
        mActive[i] = 1'b0;
      end else if (!eb && loadValid) begin
        mActive[i] = 1'b1;
        mT[i]      = cyc;
        mWord[i]   = dataIn;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic sampleAndCheck();
    logic eo, ev, ed, eb, er;
    logic ao, av, ad, ab, ar;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) {ao, av, ad, ab, ar} = {so0, sv0, fd0, busy0, ready0};
      else        {ao, av, ad, ab, ar} = {so1, sv1, fd1, busy1, ready1};
      cOut[i] = ao; cValid[i] = av; cDone[i] = ad; cBusy[i] = ab; cReady[i] = ar;
      modelExpect(i, eo, ev, ed, eb, er);
      checkOutput($sformatf("dut%0d.shift_out", i),   32'(ao), 32'(eo));
      checkOutput($sformatf("dut%0d.shift_valid", i), 32'(av), 32'(ev));
      checkOutput($sformatf("dut%0d.frame_done", i),  32'(ad), 32'(ed));
      checkOutput($sformatf("dut%0d.busy", i),        32'(ab), 32'(eb));
      checkOutput($sformatf("dut%0d.load_ready", i),  32'(ar), 32'(er));
    end
  endtask

  // One cycle: drive inputs, check mid-cycle, then take the edge.
  task automatic applyStimulus(input logic r, input logic lv, input logic [7:0] d);
    rst       = r;
    loadValid = lv;
    dataIn    = d;
    @(negedge clk);
    sampleAndCheck();
    @(posedge clk);
    modelEdge();
    cyc++;
    #1;
  endtask

  task automatic waitIdle();
    bit done;
    done      = 1'b0;
    rst       = 1'b0;
    loadValid = 1'b0;
    dataIn    = 8'h00;
    for (int n = 0; n < 80 && !done; n++) begin
      #1;
      if (ready0 && ready1) done = 1'b1;
      else applyStimulus(1'b0, 1'b0, 8'h00);
    end
    if (!done) checkOutput("waitIdle.timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] m1, m2, m3, m4;
  logic [7:0]  bits;
  int          acc2;
  int          cnt;

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 12};
    vecs[1] = '{8'h00, 8'h00, 0};
    vecs[2] = '{8'hFF, 8'hFF, 24};
    vecs[3] = '{8'h81, 8'h81, 6};
    vecs[4] = '{8'h7E, 8'h7E, 18};
    vecs[5] = '{8'h01, 8'h01, 3};

    mActive[0] = 1'b0; mActive[1] = 1'b0;
    mT[0] = 0; mT[1] = 0;
    mWord[0] = 8'h00; mWord[1] = 8'h00;

    rst = 1'b1; loadValid = 1'b1; dataIn = 8'hFF;
    @(posedge clk);
    modelEdge();
    cyc++;
    #1;

    // Reset held with a pending word.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 8'hFF);
      checkOutput("rst.valid0", 32'(cValid[0]), 32'd0);
      checkOutput("rst.busy0",  32'(cBusy[0]),  32'd0);
      checkOutput("rst.ready0", 32'(cReady[0]), 32'd0);
      checkOutput("rst.busy1",  32'(cBusy[1]),  32'd0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("rst.readyFirst", 32'(cReady[0]), 32'd1);

    // Loopback into the receiver.
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'hA5);
    bits = 8'h00; m1 = '0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      bits = {bits[6:0], cOut[0]};
      m1  |= 32'(cDone[0]) << k;
    end
    checkOutput("loop.bits",   32'(bits), 32'h0000_00A5);
    checkOutput("loop.doneAt", m1,        32'h0000_0100);
    checkOutput("loop.rx",     32'(rx),   32'h0000_00A5);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("loop.readyT9", 32'(cReady[0]), 32'd1);

    // Paced frame on dut1.
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'h81);
    m1 = '0; m2 = '0; m3 = '0; m4 = '0;
    for (int k = 1; k <= 27; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      m1 |= 32'(cOut[1])   << k;
      m2 |= 32'(cDone[1])  << k;
      m3 |= 32'(cBusy[1])  << k;
      m4 |= 32'(cReady[1]) << k;
    end
    checkOutput("pace.out",   m1, 32'h01C0_000E);
    checkOutput("pace.done",  m2, 32'h0100_0000);
    checkOutput("pace.busy",  m3, 32'h07FF_FFFE);
    checkOutput("pace.ready", m4, 32'h0800_0000);

    // Back-to-back with load_valid held high.
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'h0F);
    acc2 = 0; m1 = '0; m2 = '0;
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(1'b0, 1'b1, 8'hF0);
      m1 |= 32'(cValid[0]) << k;
      m2 |= 32'(cOut[0])   << k;
      if (cReady[0] && acc2 == 0) acc2 = k;
    end
    checkOutput("b2b.secondAccept", 32'(acc2), 32'd9);
    checkOutput("b2b.valid",        m1,        32'h0003_FDFE);
    checkOutput("b2b.out",          m2,        32'h0000_3DE0);

    // Reset during bit 3 aborts the frame.
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'hFF);
    for (int k = 1; k <= 3; k++) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("abort.validDuring", 32'(cValid[0]), 32'd1);
    m1 = '0;
    for (int k = 5; k <= 14; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      if (k == 5) begin
        checkOutput("abort.validAfter", 32'(cValid[0]), 32'd0);
        checkOutput("abort.outAfter",   32'(cOut[0]),   32'd0);
      end
      m1 |= 32'(cDone[0]) << k;
    end
    checkOutput("abort.noDone", m1, 32'd0);
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'h3C);
    bits = 8'h00; m2 = '0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      bits = {bits[6:0], cOut[0]};
      m2  |= 32'(cValid[0]) << k;
    end
    checkOutput("abort.nextBits",  32'(bits), 32'h0000_003C);
    checkOutput("abort.nextValid", m2,        32'h0000_01FE);

    // Load pulse while busy is ignored.
    waitIdle();
    applyStimulus(1'b0, 1'b1, 8'hC3);
    bits = 8'h00; m1 = '0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) applyStimulus(1'b0, 1'b1, 8'h55);
      else        applyStimulus(1'b0, 1'b0, 8'h00);
      if (k <= 8) bits = {bits[6:0], cOut[0]};
      else        m1 |= 32'(cValid[0]) << k;
    end
    checkOutput("ignore.bits",    32'(bits), 32'h0000_00C3);
    checkOutput("ignore.noFrame", m1,        32'd0);

    // Table of single frames through both instances.
    for (int v = 0; v < 6; v++) begin
      waitIdle();
      applyStimulus(1'b0, 1'b1, vecs[v].dataIn);
      cnt = 0;
      for (int k = 1; k <= 27; k++) begin
        applyStimulus(1'b0, 1'b0, 8'h00);
        cnt += int'(cOut[1]);
        if (k == 8) checkOutput($sformatf("vec%0d.rx", v), 32'(rx), 32'(vecs[v].expRx));
      end
      checkOutput($sformatf("vec%0d.high1", v), 32'(cnt), 32'(vecs[v].expHigh1));
    end

    // Random traffic with occasional resets, checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer_tx.md
# piso_serializer_tx

Parallel-in, serial-out transmitter that serializes a WIDTH-bit word MSB-first onto a single-bit line. It is the transmit end of the team's 8-bit shift-register receive path. An 8-bit shift-left receiver on the same clk, with its shift_in tied to shift_out, holds the transmitted word after one frame when BIT_CYCLES=1. A valid/ready handshake accepts words, and a programmable bit period and inter-frame gap let the block pace slower receivers.

## Interface
- WIDTH, 8, word width in bits; must be at least 2.
- BIT_CYCLES, 1, clk cycles each bit is held on shift_out; must be at least 1.
- GAP_CYCLES, 0, idle cycles after each frame before the next load is accepted; may be 0.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  WIDTH  word to transmit; sampled only on the accepting edge.
- load_valid  in  1  requester has a word on data_in.
- load_ready  out  1  block can accept a word; equals (state==IDLE) & ~rst.
- shift_out  out  WIDTH=1  serial data, MSB first; 0 whenever shift_valid=0.
- shift_valid  out  1  shift_out carries a frame bit this cycle.
- frame_done  out  1  one-cycle pulse during the final cycle of the last bit.
- busy  out  1  state is not IDLE.

## Operation
- Datapath registers:
  - shift register sreg[WIDTH-1:0];
  - bit counter bit_cnt, range 0..WIDTH-1, width clog2(WIDTH);
  - period counter per_cnt, range 0..BIT_CYCLES-1;
  - gap counter gap_cnt, range 0..GAP_CYCLES-1.
- States:
  - IDLE: load_ready=1.
  - SHIFT: shift_valid=1.
  - GAP: all outputs idle except busy=1.
- IDLE -> SHIFT on the edge where load_valid & load_ready. On that edge:
  - sreg <= data_in;
  - bit_cnt <= 0;
  - per_cnt <= 0.
- In SHIFT:
  - shift_out = sreg[WIDTH-1].
  - per_cnt increments each cycle.
  - When per_cnt==BIT_CYCLES-1: per_cnt <= 0, sreg <= {sreg[WIDTH-2:0],1'b0}, bit_cnt increments.
- Last bit means bit_cnt==WIDTH-1 && per_cnt==BIT_CYCLES-1. In that cycle frame_done=1. The next state is:
  - GAP if GAP_CYCLES>0, with gap_cnt <= 0;
  - IDLE otherwise.
- In GAP: gap_cnt increments each cycle; when gap_cnt==GAP_CYCLES-1, next state is IDLE.
- load_valid is ignored outside IDLE. A word is never queued or dropped silently, because load_ready=0 there.
- data_in changes after acceptance do not affect the frame in flight.
- Counters never wrap within a frame. Each counter is reset to 0 at the start of its own phase.
- Reset:
  - Any edge with rst=1 forces IDLE and sreg=0 and clears all counters. This aborts a frame mid-bit; no frame_done is generated.
  - Outputs while rst=1 and after the reset edge: shift_out=0, shift_valid=0, frame_done=0, busy=0, load_ready=0 (forced by ~rst).
  - load_ready rises in the first cycle with rst=0.
- Simultaneous rst and load_valid: rst wins and the word is not accepted.

## Timing
- Latency: accepting edge at cycle T.
  - First bit (MSB) is valid in cycles T+1 .. T+BIT_CYCLES.
  - Bit k (k=0 is the MSB) is valid in cycles T+1+k*BIT_CYCLES .. T+(k+1)*BIT_CYCLES.
- frame_done is high in cycle T+WIDTH*BIT_CYCLES.
- load_ready is high again in cycle T+WIDTH*BIT_CYCLES+GAP_CYCLES+1.
- Minimum frame period is WIDTH*BIT_CYCLES+GAP_CYCLES+1 cycles. The one cycle spent in IDLE is mandatory; there is no back-to-back acceptance during the last bit.
- shift_valid is high for exactly WIDTH*BIT_CYCLES consecutive cycles per frame.
- All outputs are decoded from registered state, with no combinational path from load_valid or data_in. The only exception is load_ready's dependence on rst.

## Test plan
- Reset: hold rst=1 for 3 cycles with load_valid=1 and data_in=8'hFF. Required: no acceptance, shift_valid=0, busy=0, load_ready=0. After rst falls, load_ready=1 in the first cycle.
- Loopback: defaults; load 8'hA5 with an 8-bit SIPO receiver on the same clk fed by shift_out. Required:
  - shift_out sequence 1,0,1,0,0,1,0,1 in cycles T+1..T+8;
  - frame_done at T+8;
  - receiver out=8'hA5 after edge T+8;
  - load_ready=1 at T+9.
- Pacing: BIT_CYCLES=3, GAP_CYCLES=2, load 8'h81. Required:
  - shift_out=1 for 3 cycles, then 0 for 18 cycles, then 1 for 3 cycles;
  - frame_done at T+24;
  - busy through T+26;
  - load_ready at T+27.
- Back-to-back: load_valid held high with 8'h0F then 8'hF0 under defaults. Required: second acceptance exactly 9 cycles after the first, and output bits 00001111 then 11110000 with one idle (shift_valid=0) cycle between them.
- Abort: load 8'hFF and assert rst during bit 3 for one cycle. Required:
  - shift_valid=0 and shift_out=0 the cycle after the reset edge;
  - no frame_done;
  - the next load of 8'h3C transmits 00111100 cleanly.
- Ignored load: while busy, pulse load_valid with 8'h55. Required: the frame in flight is unchanged, and 8'h55 is never transmitted unless load_valid is still asserted when load_ready returns.
